// File: rtl/ad936x_rx_sample_fifo_pkg.sv
// Shared types and widths for the AD936x RX sample path.
package ad936x_pkg;

  localparam int AD936X_SAMPLE_WIDTH  = 12;
  localparam int OVERFLOW_COUNT_WIDTH = 16;

  typedef struct packed {
    logic [11:0] i;
    logic [11:0] q;
  } iq_sample_t;

endpackage

// File: rtl/ad936x_rx_sample_fifo_if.sv
// Ready/valid I/Q handshake between the BBP RX port, the sample FIFO and its consumer.
interface ad936x_rx_sample_fifo_if
  import ad936x_pkg::*;
#(
  parameter int WIDTH = AD936X_SAMPLE_WIDTH
) ();

  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] in_q;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_i;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_i, in_q, in_valid, out_ready,
    input  in_ready, out_i, out_q, out_valid
  );

  modport slave (
    input  in_i, in_q, in_valid, out_ready,
    output in_ready, out_i, out_q, out_valid
  );

endinterface

// File: rtl/ad936x_rx_sample_fifo_ram.sv
// Simple dual-port sample store: registered write, registered read-first read.
module iq_fifo_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ad936x_rx_sample_fifo.sv
// FWFT elastic buffer for AD936x RX I/Q pairs with level reporting and an overflow counter.
module ad936x_rx_sample_fifo
  import ad936x_pkg::*;
#(
  parameter int WIDTH        = AD936X_SAMPLE_WIDTH,
  parameter int DEPTH        = 16,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  ad936x_rx_sample_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]          level,
  output logic [OVERFLOW_COUNT_WIDTH-1:0] overflow_count,
  input  logic                            clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = 2 * WIDTH;

  function automatic logic [OVERFLOW_COUNT_WIDTH-1:0] sat_inc(
    input logic [OVERFLOW_COUNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + OVERFLOW_COUNT_WIDTH'(1);
  endfunction

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_q, in_ready_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [OVERFLOW_COUNT_WIDTH-1:0] ovf_q, ovf_d;
  logic          byp_vld_q, byp_vld_d;
  logic [DW-1:0] byp_data_q, byp_data_d;

  logic [DW-1:0] in_data, head_data, ram_rdata;
  logic push, pop, full, accept, drop, slot_free, ram_avail, ram_rd, ram_we;

  always_comb begin
    in_data    = {bus.in_i, bus.in_q};
    push       = bus.in_valid & in_ready_q;
    pop        = out_vld_q & bus.out_ready;
    full       = (level_q == LW'(DEPTH));
    accept     = push & ~full;
    drop       = push & full;
    slot_free  = ~out_vld_q | pop;
    // Everything not in the output register lives in the RAM.
    ram_avail  = (level_q > {{(LW-1){1'b0}}, out_vld_q});
    // The RAM read was issued last cycle; a same-address write then is caught by the bypass.
    head_data  = byp_vld_q ? byp_data_q : ram_rdata;

    ram_rd     = slot_free & ram_avail;
    ram_we     = accept & ~(slot_free & ~ram_avail);

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (slot_free) begin
      out_vld_d = ram_avail | accept;
      if (ram_avail)   out_data_d = head_data;
      else if (accept) out_data_d = in_data;
    end

    rd_ptr_d = ram_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = ram_we ? wr_ptr_q + PW'(1) : wr_ptr_q;

    case ({accept, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    in_ready_d = DROP_ON_FULL ? 1'b1 : (level_d < LW'(DEPTH));

    if (clear_overflow) ovf_d = '0;
    else if (drop)      ovf_d = sat_inc(ovf_q);
    else                ovf_d = ovf_q;

    byp_vld_d  = ram_we & (wr_ptr_q == rd_ptr_d);
    byp_data_d = in_data;
  end

  // Registered state: control and visible outputs reset, bypass data does not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= '0;
      byp_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      byp_vld_q  <= byp_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    byp_data_q <= byp_data_d;
  end

  iq_fifo_ram #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_d),
    .rdata (ram_rdata)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_i       = out_data_q[DW-1:WIDTH];
  assign bus.out_q       = out_data_q[WIDTH-1:0];
  assign level           = level_q;
  assign overflow_count  = ovf_q;

endmodule
